// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA sync path.
// Holds the default 800x600@60 Hz (40 MHz) set, a 640x480@60 Hz (25 MHz) alternate set,
// the address width used for counters and pixel addresses, and a small total helper.
package vga_timing_pkg;

  localparam int unsigned AddrWidth = 12;
  localparam int unsigned MaxTotal  = 4096;

  typedef logic [AddrWidth-1:0] addr_t;

  // 800x600@60 Hz, 40 MHz pixel clock
  localparam int unsigned Svga800HSync   = 128;
  localparam int unsigned Svga800HBack   = 88;
  localparam int unsigned Svga800HActive = 800;
  localparam int unsigned Svga800HFront  = 40;
  localparam int unsigned Svga800VSync   = 4;
  localparam int unsigned Svga800VBack   = 23;
  localparam int unsigned Svga800VActive = 600;
  localparam int unsigned Svga800VFront  = 1;

  // 640x480@60 Hz, 25 MHz pixel clock
  localparam int unsigned Vga640HSync   = 96;
  localparam int unsigned Vga640HBack   = 48;
  localparam int unsigned Vga640HActive = 640;
  localparam int unsigned Vga640HFront  = 16;
  localparam int unsigned Vga640VSync   = 2;
  localparam int unsigned Vga640VBack   = 33;
  localparam int unsigned Vga640VActive = 480;
  localparam int unsigned Vga640VFront  = 10;

  function automatic int unsigned axis_total(int unsigned sync, int unsigned back,
                                             int unsigned active, int unsigned front);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with sync/active decode.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          advance the count this cycle
//   count       current position, 0 at the first sync cycle
//   wrap        en is high and count is at the last position of the axis
//   in_sync     count lies in the sync interval
//   in_active   count lies in the visible interval
//   offset      count relative to the first visible position; 0 outside the visible interval
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC   = Svga800HSync,
  parameter int unsigned BACK   = Svga800HBack,
  parameter int unsigned ACTIVE = Svga800HActive,
  parameter int unsigned FRONT  = Svga800HFront
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  output addr_t count,
  output logic  wrap,
  output logic  in_sync,
  output logic  in_active,
  output addr_t offset
);

  localparam int unsigned Total    = axis_total(SYNC, BACK, ACTIVE, FRONT);
  localparam int unsigned ActStart = SYNC + BACK;
  localparam int unsigned ActEnd   = ActStart + ACTIVE;
  localparam addr_t       Last     = addr_t'(Total - 1);

  if (Total > MaxTotal || Total == 0) begin : g_bad_total
    $error("vga_axis_counter: axis total %0d outside 1..%0d", Total, MaxTotal);
  end

  addr_t       count_q, count_d;
  logic [31:0] count_ext;

  assign count_ext = 32'(count_q);
  assign wrap      = en && (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + addr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign in_sync   = count_ext < SYNC;
  assign in_active = (count_ext >= ActStart) && (count_ext < ActEnd);
  assign offset    = in_active ? count_q - addr_t'(ActStart) : '0;

endmodule

// File: rtl/vga_sync_module.sv
// VGA raster timing generator running on the pixel clock.
// Ports:
//   vga_clk          pixel clock, one clock per pixel
//   rst_n            asynchronous active-low reset
//   HSYNC_Sig        horizontal sync, at SYNC_POL while asserted
//   VSYNC_Sig        vertical sync, at SYNC_POL while asserted
//   Ready_Sig        current position is visible
//   Column_Addr_Sig  visible column, 0 when not visible
//   Row_Addr_Sig     visible row, 0 when not visible
//   Frame_Start_Sig  one-cycle pulse for position (h=0, v=0)
// All outputs are registered decodes of the counter values of the same edge, so they lag the
// counters by one clock and stay aligned with each other.
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = Svga800HSync,
  parameter int unsigned H_BACK   = Svga800HBack,
  parameter int unsigned H_ACTIVE = Svga800HActive,
  parameter int unsigned H_FRONT  = Svga800HFront,
  parameter int unsigned V_SYNC   = Svga800VSync,
  parameter int unsigned V_BACK   = Svga800VBack,
  parameter int unsigned V_ACTIVE = Svga800VActive,
  parameter int unsigned V_FRONT  = Svga800VFront,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Ready_Sig,
  output logic [11:0] Column_Addr_Sig,
  output logic [11:0] Row_Addr_Sig,
  output logic        Frame_Start_Sig
);

  addr_t h_cnt, v_cnt, h_off, v_off;
  logic  h_wrap, h_sync, h_act;
  logic  v_sync, v_act;
  logic  unused_v_wrap;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_axis (
    .clk       (vga_clk),
    .rst_n     (rst_n),
    .en        (1'b1),
    .count     (h_cnt),
    .wrap      (h_wrap),
    .in_sync   (h_sync),
    .in_active (h_act),
    .offset    (h_off)
  );

  // Vertical axis steps once per line, on the last pixel of the line.
  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_axis (
    .clk       (vga_clk),
    .rst_n     (rst_n),
    .en        (h_wrap),
    .count     (v_cnt),
    .wrap      (unused_v_wrap),
    .in_sync   (v_sync),
    .in_active (v_act),
    .offset    (v_off)
  );

  logic  hsync_d, vsync_d, ready_d, fs_d;
  addr_t col_d, row_d;
  logic  hsync_q, vsync_q, ready_q, fs_q;
  addr_t col_q, row_q;

  always_comb begin
    hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
    vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
    ready_d = h_act && v_act;
    // Gate on the joint condition: an axis offset alone can be non-zero outside the window.
    col_d   = ready_d ? h_off : '0;
    row_d   = ready_d ? v_off : '0;
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ready_q <= ready_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fs_q    <= fs_d;
    end
  end

  assign HSYNC_Sig       = hsync_q;
  assign VSYNC_Sig       = vsync_q;
  assign Ready_Sig       = ready_q;
  assign Column_Addr_Sig = col_q;
  assign Row_Addr_Sig    = row_q;
  assign Frame_Start_Sig = fs_q;

endmodule
